// File: rtl/spi_readout_shifter.sv
// spi_readout_shifter
// ---------------------------------------------------------------------------
// Readout transmitter for the SPI peripheral. When msg_flag strobes, the byte
// addressed by addr is taken from the flat register image and latched. The
// latched byte is then shifted out MSB-first on serial_out over the following
// sclk rising edges. A new frame can start on the edge right after the final
// bit, so frames follow each other with no gap. A msg_flag that arrives
// mid-frame is ignored and sets the sticky overrun flag.
//
// Optional feature: define READOUT_PARITY_EN to append an even-parity bit
// after bit 0, giving 9-bit frames. When the macro is not defined, frames
// are 8 bits long.
//
// Parameters:
//   NUM_REGS   number of 8-bit registers in reg_bus (valid addr 0..NUM_REGS-1)
//   OOR_VALUE  byte sent for addr >= NUM_REGS
// Ports:
//   sclk        in   serial clock, rising-edge active
//   rstn        in   asynchronous active-low reset
//   msg_flag    in   one-cycle word-complete strobe (load request)
//   addr        in   [7:0] register address, sampled with msg_flag
//   reg_bus     in   [8*NUM_REGS-1:0] register image, byte a at [8a+7:8a]
//   serial_out  out  registered serial data
//   busy        out  frame in progress
//   frame_done  out  pulse on the edge that presents the final bit of a frame
//   overrun     out  sticky, a msg_flag arrived mid-frame
// ---------------------------------------------------------------------------
module spi_readout_shifter #(
  parameter int          NUM_REGS  = 60,
  parameter logic [7:0]  OOR_VALUE = 8'hEE
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  msg_flag,
  input  logic [7:0]            addr,
  input  logic [8*NUM_REGS-1:0] reg_bus,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       serial_q, serial_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       overrun_q, overrun_d;
`ifdef READOUT_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // Split the flat register image into bytes.
  logic [7:0] reg_bytes [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bytes
      assign reg_bytes[gi] = reg_bus[8*gi +: 8];
    end
  endgenerate

  // Byte select. Address 0 is reserved and always reads as zero.
  logic [7:0] sel_byte;
  always_comb begin
    sel_byte = OOR_VALUE;
    if (addr == 8'd0) begin
      sel_byte = 8'h00;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (int'(addr) == i) sel_byte = reg_bytes[i];
      end
    end
  end

  always_comb begin
    logic load;
    logic frame_end;

    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
`ifdef READOUT_PARITY_EN
    parity_d  = parity_q;
`endif
    load      = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b0;
        busy_d   = 1'b0;
        load     = msg_flag;
      end

      SHIFT: begin
        if (cnt_q != 3'd0) begin
          // The next lower bit sits at [6] before this shift.
          shift_d  = {shift_q[6:0], 1'b0};
          serial_d = shift_q[6];
          cnt_d    = cnt_q - 3'd1;
          if (msg_flag) overrun_d = 1'b1;
`ifndef READOUT_PARITY_EN
          done_d   = (cnt_q == 3'd1);
`endif
        end else begin
`ifdef READOUT_PARITY_EN
          // Bit 0 is on the pin but the parity bit still has to follow, so a
          // load request is still mid-frame here.
          state_d  = PARITY;
          serial_d = parity_q;
          done_d   = 1'b1;
          if (msg_flag) overrun_d = 1'b1;
`else
          frame_end = 1'b1;
`endif
        end
      end

`ifdef READOUT_PARITY_EN
      PARITY: frame_end = 1'b1;
`endif

      default: begin
        state_d  = IDLE;
        serial_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // The final bit is on the pin. A load request on this edge starts the
    // next frame directly, so no idle 0 bit is inserted between frames.
    if (frame_end) begin
      if (msg_flag) begin
        load = 1'b1;
      end else begin
        state_d  = IDLE;
        serial_d = 1'b0;
        busy_d   = 1'b0;
      end
    end

    if (load) begin
      shift_d  = sel_byte;
      serial_d = sel_byte[7];
      cnt_d    = 3'd7;
      state_d  = SHIFT;
      busy_d   = 1'b1;
`ifdef READOUT_PARITY_EN
      parity_d = ^sel_byte;
`endif
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      cnt_q     <= 3'd0;
      serial_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef READOUT_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef READOUT_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_readout_shifter.sv
// Testbench for spi_readout_shifter. It uses directed scenarios followed by a
// randomized phase. A frame-level reference model keeps a queue of the bits
// still to be transmitted.
module tb_spi_readout_shifter;

  localparam int NUM_REGS = 60;
`ifdef READOUT_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic                  sclk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  msg_flag = 1'b0;
  logic [7:0]            addr = 8'd0;
  logic [8*NUM_REGS-1:0] reg_bus = '0;
  logic                  serial_out, busy, frame_done, overrun;

  spi_readout_shifter #(.NUM_REGS(NUM_REGS), .OOR_VALUE(8'hEE)) dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .msg_flag   (msg_flag),
    .addr       (addr),
    .reg_bus    (reg_bus),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: bits still to be presented after the current one.
  bit   q_bits[$];
  logic m_serial = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_ovr = 1'b0;

  function automatic logic [7:0] ref_byte(input logic [7:0] a);
    if (a == 8'd0) return 8'h00;
    if (int'(a) < NUM_REGS) return reg_bus[8*int'(a) +: 8];
    return 8'hEE;
  endfunction

  task automatic model_reset();
    q_bits.delete();
    m_serial = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_edge(input logic m, input logic [7:0] a);
    logic [7:0] b;
    if (q_bits.size() == 0) begin
      // Idle, or the final bit is currently presented: a request loads.
      if (m) begin
        b = ref_byte(a);
        for (int i = 7; i >= 0; i--) q_bits.push_back(b[i]);
`ifdef READOUT_PARITY_EN
        q_bits.push_back(^b);
`endif
        m_serial = q_bits.pop_front();
        m_busy   = 1'b1;
        m_done   = 1'b0;
      end else begin
        m_serial = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end
    end else begin
      if (m) m_ovr = 1'b1;
      m_serial = q_bits.pop_front();
      m_busy   = 1'b1;
      m_done   = (q_bits.size() == 0);
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_serial"}, serial_out, m_serial);
    check({tag, "_busy"},   busy,       m_busy);
    check({tag, "_done"},   frame_done, m_done);
    check({tag, "_ovr"},    overrun,    m_ovr);
  endtask

  // One rising edge. Inputs are driven between edges and outputs are
  // sampled on the falling edge.
  task automatic edge_step(input logic m, input logic [7:0] a, input string tag);
    msg_flag = m;
    addr     = a;
    model_edge(m, a);
    @(posedge sclk);
    @(negedge sclk);
    check_all(tag);
    $display("edge %-8s msg=%b addr=%3d serial=%b busy=%b done=%b ovr=%b",
             tag, m, a, serial_out, busy, frame_done, overrun);
    msg_flag = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;

    // Reset state
    repeat (2) @(negedge sclk);
    check_all("reset");
    rstn = 1'b1;
    edge_step(1'b0, 8'd0, "idle");

    // A5 from address 5, also checked against the literal bit pattern
    reg_bus[8*5 +: 8] = 8'hA5;
    pat = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      edge_step(k == 0, 8'd5, "a5");
      check("a5_bit", serial_out, pat[7-k]);
    end
    repeat (FRAME_LEN - 8 + 2) edge_step(1'b0, 8'd0, "a5_tail");

    // Reserved address and out-of-range address
    edge_step(1'b1, 8'd0, "addr0");
    repeat (FRAME_LEN) edge_step(1'b0, 8'd0, "addr0");
    edge_step(1'b1, 8'd200, "oor");
    repeat (FRAME_LEN) edge_step(1'b0, 8'd0, "oor");

    // Gapless streaming of three frames
    reg_bus[8*1 +: 8] = 8'h01;
    reg_bus[8*2 +: 8] = 8'h80;
    reg_bus[8*3 +: 8] = 8'hFF;
    for (int f = 0; f < 3; f++) begin
      edge_step(1'b1, 8'(f + 1), "stream");
      repeat (FRAME_LEN - 1) edge_step(1'b0, 8'd0, "stream");
    end
    edge_step(1'b0, 8'd0, "stream_end");

    // Overrun: an extra request at +3 is ignored and sets the sticky flag
    reg_bus[8*7 +: 8] = 8'h3C;
    edge_step(1'b1, 8'd7, "ovr");
    edge_step(1'b0, 8'd0, "ovr");
    edge_step(1'b0, 8'd0, "ovr");
    edge_step(1'b1, 8'd9, "ovr_hit");
    repeat (FRAME_LEN + 2) edge_step(1'b0, 8'd0, "ovr");

    // Snapshot: the byte changes at +2, then reset is pulsed after +4
    reg_bus[8*4 +: 8] = 8'h96;
    edge_step(1'b1, 8'd4, "snap");
    edge_step(1'b0, 8'd0, "snap");
    reg_bus[8*4 +: 8] = 8'h69;
    edge_step(1'b0, 8'd3, "snap");
    edge_step(1'b0, 8'd0, "snap");
    edge_step(1'b0, 8'd0, "snap");
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1;
    rstn = 1'b1;
    edge_step(1'b0, 8'd0, "post_rst");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0)
        reg_bus[8*$urandom_range(0, NUM_REGS-1) +: 8] = 8'($urandom);
      edge_step($urandom_range(0, 5) == 0,
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, NUM_REGS-1)),
                "rand");
    end

    // Overrun clears only on reset
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("final_rst");
    #1;
    rstn = 1'b1;
    edge_step(1'b0, 8'd0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/spi_readout_shifter.md
# spi_readout_shifter

Readout transmitter for the SPI peripheral: the outbound counterpart to the inbound shift/decode path. On each word-complete strobe it snapshots the register addressed by the current address pointer and shifts it MSB-first onto `serial_out` across the following sclk edges. It sits between the address pointer / `msg_flag` generator and the chip's serial output pin. It provides back-to-back frames, overrun detection and an optional parity bit.

## Interface
- `NUM_REGS`, 60: number of addressable 8-bit registers; valid addresses are 0..NUM_REGS-1.
- `OOR_VALUE`, 8'hEE: byte transmitted for addresses >= NUM_REGS.

Ports:
- `sclk`  in  1: serial clock; all state updates on the rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `msg_flag`  in  1: word-complete strobe, high for exactly one sclk cycle.
- `addr`  in  8: current address pointer; sampled only when `msg_flag`=1.
- `reg_bus`  in  8*NUM_REGS: flat register image; byte a is `reg_bus[8a+7:8a]`.
- `serial_out`  out  1: serial readout data.
- `busy`  out  1: a frame is in progress.
- `frame_done`  out  1: one-cycle pulse on the edge that presents the final bit of a frame.
- `overrun`  out  1: sticky; a `msg_flag` arrived mid-frame.

## Operation
- Reset values: `serial_out`=0, `busy`=0, `frame_done`=0, `overrun`=0, bit counter 0, shift register 0, state IDLE. Reset is asynchronous and aborts any frame immediately.
- Byte select on load:
  - addr 0 → 8'h00 (reserved).
  - 1..NUM_REGS-1 → `reg_bus` byte addr.
  - >= NUM_REGS → `OOR_VALUE`.
- Snapshot rule: the selected byte is latched on the load edge. Later `reg_bus` or `addr` changes do not alter the frame in flight.
- States:
  - IDLE: `serial_out` held 0, `busy`=0. On `msg_flag`=1, load the snapshot, drive `serial_out` to bit 7, set bit counter to 7, go to SHIFT.
  - SHIFT: each edge shifts left and presents the next lower bit. The edge presenting bit 0 is the last edge (or PARITY when configured). On the edge after the last bit, return to IDLE with `serial_out`=0, unless a reload occurs.
  - PARITY (only with macro): one edge presenting the parity bit, then behaves as the last edge.
- Back-to-back rule: `msg_flag`=1 on the edge after the last bit (the IDLE-return edge) reloads directly. The next frame starts gapless, `busy` stays 1, and no 0 bit is inserted.
- Overrun:
  - `msg_flag`=1 while in SHIFT/PARITY before the last bit has been presented: the request is ignored, the frame continues, and `overrun` is set.
  - `overrun` clears only on reset.
- `frame_done`: high exactly on the edge presenting the final bit (bit 0, or parity), low on the next edge.

## Timing
- Load latency: 0 cycles. Bit 7 appears on `serial_out` on the same rising edge that samples `msg_flag`=1.
- Frame length: 8 sclk edges (9 with parity). Bit k (7..0) is valid from edge (7-k) to edge (8-k) after load.
- Host samples `serial_out` on the falling sclk edge; the output is registered, so it is glitch-free.
- `busy`: rises on the load edge and falls on the edge after the final bit, unless reloaded.
- Minimum `msg_flag` spacing for loss-free streaming: 8 edges (9 with parity).

## Configuration
- `READOUT_PARITY_EN` defined: each frame appends one even-parity bit (XOR of the 8 data bits) after bit 0. Frame length is 9, and `frame_done` and the last-bit/reload rules apply to the parity edge.
- Undefined: no PARITY state; frames are exactly 8 bits.

## Test plan
- Reset, then `msg_flag` with addr=5 and byte5=8'hA5 → `serial_out` shows 1,0,1,0,0,1,0,1 on load edge +0..+7. `frame_done` pulses at +7, `busy` falls at +8, and `serial_out`=0 afterwards.
- addr=0 → eight 0 bits. addr=200 → 8'hEE serialized (1,1,1,0,1,1,1,0).
- Streaming: `msg_flag` every 8 edges with addr 1,2,3 and bytes 8'h01,8'h80,8'hFF → 24 contiguous bits with `busy` held 1 throughout and `overrun`=0.
- Extra `msg_flag` at edge +3 of a frame → frame bits unchanged, `overrun`=1 from the next edge and held until `rstn` falls.
- `reg_bus` byte changed at edge +2 → transmitted byte equals the load-edge snapshot. `rstn` pulsed low at edge +4 → all outputs 0 immediately and state is IDLE.
- With `READOUT_PARITY_EN`: 8'h07 → 8 data bits followed by parity 1, `frame_done` at +8. 8'h03 → parity 0.
